// File: rtl/pwm_timer_pkg.sv
// Shared definitions for the PWM timer core.
//   - arb_state_t : state encoding of the prescale arbiter FSM
//   - RAT_W / MAX_RAT / DEF_RAT : divider ratio width, largest legal ratio, reset ratio
//   - ratio_legal() : legality rule for a requested divider update
package pwm_timer_pkg;

  localparam int RAT_W   = 16;
  localparam int MAX_RAT = 255;
  localparam int DEF_RAT = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_BND = 2'd1,
    RESP     = 2'd2
  } arb_state_t;

  // A disable request carries no ratio, so it is always legal. An enable
  // request needs a ratio the divider can realise: at least 2 (a ratio of 1
  // would give no divided period at all) and no more than max_rat.
  function automatic logic ratio_legal(input logic        en,
                                       input logic [31:0] rat,
                                       input logic [31:0] max_rat);
    return !en || ((rat >= 32'd2) && (rat <= max_rat));
  endfunction

endpackage

// File: rtl/pwm_rr_picker.sv
// Combinational round-robin first-one finder.
// Ports:
//   req [NUM_REQ-1:0] : request vector
//   ptr [IDX_W-1:0]   : index with highest priority this cycle
//   idx [IDX_W-1:0]   : first set request at or after ptr, wrapping
//   vld               : at least one request is set (idx meaningful)
module pwm_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest position back toward ptr so the last hit written
  // is the nearest one in round-robin order.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_prescale_arbiter.sv
// Shares the PWM core clock divider among NUM_REQ channel controllers.
// Requests are arbitrated round-robin, the ratio is validated, and an accepted
// update is applied only on a divided-period boundary (or immediately when the
// divider is stopped) so the divided clock never sees a truncated period.
// Ports:
//   ref_clk     : reference clock (the divider's clock)
//   rst         : asynchronous active-high reset
//   req         : per-channel update request, level, held until gnt/nack
//   req_en      : per-channel requested divider enable
//   req_rat     : per-channel requested ratio, channel i at [i*RAT_W +: RAT_W]
//   gnt / nack  : one-cycle accept / reject pulse to the served channel
//   div_rat     : ratio driven to the divider
//   div_clk_en  : enable driven to the divider
//   period_tick : pulse on the last ref_clk cycle of each divided period
//   busy        : an accepted update is waiting for its boundary
module pwm_prescale_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int RAT_W   = pwm_timer_pkg::RAT_W,
  parameter int MAX_RAT = pwm_timer_pkg::MAX_RAT,
  parameter int DEF_RAT = pwm_timer_pkg::DEF_RAT
) (
  input  logic                     ref_clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_en,
  input  logic [NUM_REQ*RAT_W-1:0] req_rat,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       nack,
  output logic [RAT_W-1:0]         div_rat,
  output logic                     div_clk_en,
  output logic                     period_tick,
  output logic                     busy
);

  import pwm_timer_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [RAT_W-1:0] pick_rat;
  logic             pick_legal;

  logic [IDX_W-1:0] sel_idx;
  logic             sel_en;
  logic [RAT_W-1:0] sel_rat;
  logic             sel_nack;

  logic [RAT_W-1:0] cnt;
  logic             load;
  logic             apply;
  logic             advance_ptr;

  pwm_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Constant-index mux keeps the ratio select free of variable part-selects.
  always_comb begin
    pick_rat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) pick_rat = req_rat[i*RAT_W +: RAT_W];
    end
  end

  assign pick_legal  = ratio_legal(req_en[pick_idx], 32'(pick_rat), 32'(MAX_RAT));
  assign period_tick = div_clk_en && (cnt == (div_rat - RAT_W'(1)));

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    apply       = 1'b0;
    advance_ptr = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          load      = 1'b1;
          state_nxt = pick_legal ? WAIT_BND : RESP;
        end
      end
      WAIT_BND: begin
        // A withdrawn request is dropped silently; the pointer stays put so
        // the same channel keeps its priority.
        if (!req[sel_idx]) begin
          state_nxt = IDLE;
        end else if (!div_clk_en || period_tick) begin
          apply     = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        advance_ptr = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    nack = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i]  = (state == RESP) && !sel_nack && (sel_idx == IDX_W'(i));
      nack[i] = (state == RESP) &&  sel_nack && (sel_idx == IDX_W'(i));
    end
  end

  assign busy = (state == WAIT_BND);

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      sel_idx    <= '0;
      sel_en     <= 1'b0;
      sel_rat    <= '0;
      sel_nack   <= 1'b0;
      div_rat    <= RAT_W'(DEF_RAT);
      div_clk_en <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        sel_idx  <= pick_idx;
        sel_en   <= req_en[pick_idx];
        sel_rat  <= pick_rat;
        sel_nack <= !pick_legal;
      end
      if (advance_ptr) begin
        ptr <= (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + IDX_W'(1);
      end
      // The update lands on the same edge the counter restarts, so the new
      // ratio starts with a full period.
      if (apply) begin
        div_clk_en <= sel_en;
        if (sel_en) div_rat <= sel_rat;
        cnt <= '0;
      end else if (div_clk_en) begin
        cnt <= period_tick ? '0 : cnt + RAT_W'(1);
      end
    end
  end

endmodule
